csr_trap_seq: RTL
=================

Name: csr_trap_seq

Overview:
- Initiator-side sequencer for the machine-mode CSR register file. It drives the file's address, write-data, read-strobe and write-strobe port and consumes its combinational read data.
- Turns pipeline trap events (synchronous exceptions, external and timer interrupts) and mret into ordered CSR read-modify-write sequences.
- Produces a one-cycle PC redirect and holds a stall to the core while a sequence is in flight.

Parameters:
- XLEN, 32, data width of the CSR port and PCs
- CAUSE_W, 4, width of the exception cause code

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- exc_valid  in  1  synchronous exception request (pulse or level)
- exc_cause  in  CAUSE_W  exception code, sampled with exc_valid
- exc_pc  in  XLEN  PC of the faulting instruction
- irq_ext  in  1  machine external interrupt, level
- irq_timer  in  1  machine timer interrupt, level
- irq_pc  in  XLEN  PC of the next instruction to execute (mepc for interrupts)
- mret  in  1  mret retiring
- csr_addr  out  12  CSR address
- csr_wdata  out  XLEN  CSR write data
- csr_rd  out  1  CSR read strobe
- csr_wr  out  1  CSR write strobe (written at the next clk edge)
- csr_rdata  in  XLEN  CSR read data, combinational from csr_addr/csr_rd
- stall  out  1  high whenever the FSM is not in IDLE
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  XLEN  target PC, valid with redirect_valid

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0 immediately, including csr_wr; no partial write completes. Latched cause/pc/mstatus registers cleared.
- CSR map:
  - mstatus=0x300, mie=0x304, mtvec=0x305, mepc=0x341, mcause=0x342.
  - mstatus bits: MIE=bit3, MPIE=bit7, MPP=bits12:11.
- IDLE acceptance, fixed priority: exc_valid > mret > (irq_ext|irq_timer).
  - Exception accept latches exc_cause and exc_pc.
  - Interrupt accept latches irq_pc, irq_ext and irq_timer.
  - Requests arriving outside IDLE are ignored; the core is stalled and must re-present them.
- States: IDLE, RD_MSTATUS, RD_MIE, WR_MSTATUS, WR_MEPC, WR_MCAUSE, RD_MTVEC, RD_MEPC, WR_MSTATUS_RET, REDIRECT.
- In every RD_* state: csr_rd=1, csr_wr=0, csr_addr set; csr_rdata is captured at the end of that cycle.
- In every WR_* state: csr_wr=1, csr_rd=0. Exactly one strobe is high per non-IDLE, non-REDIRECT cycle.
- Exception path: RD_MSTATUS -> WR_MSTATUS -> WR_MEPC -> WR_MCAUSE -> RD_MTVEC -> REDIRECT -> IDLE. redirect_valid is high in the 6th cycle after the accept edge.
- Interrupt path: RD_MSTATUS -> RD_MIE, then evaluate:
  - take_ext = mstatus.MIE & mie[11] & irq_ext_latched
  - take_tmr = mstatus.MIE & mie[7] & irq_timer_latched
  - If neither is set: return to IDLE with no writes and no redirect.
  - Otherwise: WR_MSTATUS -> WR_MEPC -> WR_MCAUSE -> RD_MTVEC -> REDIRECT.
  - External interrupt wins over timer when both are enabled.
- mret path: RD_MSTATUS -> WR_MSTATUS_RET -> RD_MEPC -> REDIRECT -> IDLE.
- Trap mstatus write:
  - MPIE <= old MIE
  - MIE <= 0
  - MPP <= 2'b11
  - all other bits unchanged
- mret mstatus write:
  - MIE <= old MPIE
  - MPIE <= 1
  - MPP <= 2'b11
  - all other bits unchanged
- mepc write value: {pc[XLEN-1:2], 2'b00}, using exc_pc or irq_pc.
- mcause write value:
  - exception: {1'b0, zero-extended exc_cause}
  - external interrupt: 0x8000000B
  - timer interrupt: 0x80000007
- redirect_pc:
  - trap: base = {mtvec[31:2], 2'b00}. If mtvec[1:0]==2'b01 and the trap is an interrupt, base + 4*code (code = 11 or 7). Otherwise base.
  - Address arithmetic is modulo 2^XLEN (wraps).
  - mret: {mepc[31:2], 2'b00}.
- stall: combinational, (state != IDLE). It is low in the accept cycle itself and high from the next cycle until the REDIRECT cycle inclusive.
- Back-to-back requests: a request present on the cycle the FSM returns to IDLE is accepted that cycle.

Test Plan:
- Exception: mtvec=0x00000100, mstatus=0x8, exc_valid with cause=2, exc_pc=0x40
  -> writes mstatus=0x1880, mepc=0x40, mcause=0x2; redirect_pc=0x100 pulsed 6 cycles after accept; stall high 6 cycles.
- Vectored timer interrupt: mtvec=0x201, mstatus=0x8, mie=0x80, irq_timer=1, irq_pc=0x88
  -> mepc=0x88, mcause=0x80000007, redirect_pc=0x21C.
- Masked interrupt: mstatus=0x0, irq_ext=1
  -> only two reads; no csr_wr; no redirect; back to IDLE after 2 busy cycles.
- Priority: exc_valid, mret and irq_ext all high in the same IDLE cycle
  -> exception sequence runs, mcause=exc_cause. Then with mret only: mstatus=0x1880 becomes 0x1888 and redirect_pc=mepc.
- Reset mid-sequence: deassert rst during WR_MEPC
  -> csr_wr, stall and redirect_valid drop immediately; mcause is not written; after release, a new exception runs the full sequence.
- Both irq_ext and irq_timer enabled, mtvec direct=0x300
  -> mcause=0x8000000B, redirect_pc=0x300.

Source files
------------

// File: rtl/csr_trap_seq.sv
// rtl/csr_trap_seq.sv - machine-mode trap/mret CSR read-modify-write sequencer
//
// Turns synchronous exceptions, external/timer interrupts and mret into
// ordered accesses on the machine CSR file port. It produces a one-cycle PC
// redirect at the end of each sequence and stalls the core while busy.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   exc_valid/cause/pc       synchronous exception request
//   irq_ext, irq_timer       level interrupt requests, irq_pc = next PC
//   mret                     mret retiring
//   csr_addr/wdata/rd/wr     CSR file request port
//   csr_rdata                CSR file combinational read data
//   stall                    high while the sequencer is not idle
//   redirect_valid/pc        one-cycle PC redirect
module csr_trap_seq #(
  parameter int XLEN    = 32,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_valid,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic               irq_ext,
  input  logic               irq_timer,
  input  logic [XLEN-1:0]    irq_pc,
  input  logic               mret,
  output logic [11:0]        csr_addr,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               csr_rd,
  output logic               csr_wr,
  input  logic [XLEN-1:0]    csr_rdata,
  output logic               stall,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc
);

  localparam logic [3:0] S_IDLE           = 4'd0;
  localparam logic [3:0] S_RD_MSTATUS     = 4'd1;
  localparam logic [3:0] S_RD_MIE         = 4'd2;
  localparam logic [3:0] S_WR_MSTATUS     = 4'd3;
  localparam logic [3:0] S_WR_MEPC        = 4'd4;
  localparam logic [3:0] S_WR_MCAUSE      = 4'd5;
  localparam logic [3:0] S_RD_MTVEC       = 4'd6;
  localparam logic [3:0] S_RD_MEPC        = 4'd7;
  localparam logic [3:0] S_WR_MSTATUS_RET = 4'd8;
  localparam logic [3:0] S_REDIRECT       = 4'd9;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MIE     = 12'h304;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  logic [3:0]         state, state_nxt;
  logic [CAUSE_W-1:0] cause_q;
  logic [XLEN-1:0]    pc_q;
  logic [XLEN-1:0]    mstatus_q;
  logic [XLEN-1:0]    target_q;
  logic               is_irq_q, is_mret_q;
  logic               ext_q, tmr_q;

  logic               take_ext, take_tmr;
  logic [3:0]         irq_code;
  logic [XLEN-1:0]    mst_trap, mst_ret, mcause_val, tvec_base, trap_target;

  // Interrupt enable evaluation happens while mie is on the read port.
  assign take_ext = mstatus_q[3] & csr_rdata[11] & ext_q;
  assign take_tmr = mstatus_q[3] & csr_rdata[7] & tmr_q;

  // After RD_MIE only the winning interrupt flag is left set.
  assign irq_code = ext_q ? 4'd11 : 4'd7;

  always_comb begin
    mst_trap         = mstatus_q;
    mst_trap[7]      = mstatus_q[3];
    mst_trap[3]      = 1'b0;
    mst_trap[12:11]  = 2'b11;
    mst_ret          = mstatus_q;
    mst_ret[3]       = mstatus_q[7];
    mst_ret[7]       = 1'b1;
    mst_ret[12:11]   = 2'b11;
    if (is_irq_q) mcause_val = {1'b1, {(XLEN-5){1'b0}}, irq_code};
    else          mcause_val = {{(XLEN-CAUSE_W){1'b0}}, cause_q};
    tvec_base   = {csr_rdata[XLEN-1:2], 2'b00};
    // Vectored mode only offsets interrupts; exceptions always use the base.
    if (is_irq_q && csr_rdata[1:0] == 2'b01)
      trap_target = tvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00};
    else
      trap_target = tvec_base;
  end

  always_comb begin
    state_nxt      = state;
    csr_addr       = 12'h000;
    csr_wdata      = '0;
    csr_rd         = 1'b0;
    csr_wr         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      S_IDLE: begin
        if (exc_valid || mret || irq_ext || irq_timer) state_nxt = S_RD_MSTATUS;
      end
      S_RD_MSTATUS: begin
        csr_addr = A_MSTATUS;
        csr_rd   = 1'b1;
        if (is_mret_q)     state_nxt = S_WR_MSTATUS_RET;
        else if (is_irq_q) state_nxt = S_RD_MIE;
        else               state_nxt = S_WR_MSTATUS;
      end
      S_RD_MIE: begin
        csr_addr  = A_MIE;
        csr_rd    = 1'b1;
        state_nxt = (take_ext || take_tmr) ? S_WR_MSTATUS : S_IDLE;
      end
      S_WR_MSTATUS: begin
        csr_addr  = A_MSTATUS;
        csr_wdata = mst_trap;
        csr_wr    = 1'b1;
        state_nxt = S_WR_MEPC;
      end
      S_WR_MEPC: begin
        csr_addr  = A_MEPC;
        csr_wdata = {pc_q[XLEN-1:2], 2'b00};
        csr_wr    = 1'b1;
        state_nxt = S_WR_MCAUSE;
      end
      S_WR_MCAUSE: begin
        csr_addr  = A_MCAUSE;
        csr_wdata = mcause_val;
        csr_wr    = 1'b1;
        state_nxt = S_RD_MTVEC;
      end
      S_RD_MTVEC: begin
        csr_addr  = A_MTVEC;
        csr_rd    = 1'b1;
        state_nxt = S_REDIRECT;
      end
      S_WR_MSTATUS_RET: begin
        csr_addr  = A_MSTATUS;
        csr_wdata = mst_ret;
        csr_wr    = 1'b1;
        state_nxt = S_RD_MEPC;
      end
      S_RD_MEPC: begin
        csr_addr  = A_MEPC;
        csr_rd    = 1'b1;
        state_nxt = S_REDIRECT;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cause_q   <= '0;
      pc_q      <= '0;
      mstatus_q <= '0;
      target_q  <= '0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
      ext_q     <= 1'b0;
      tmr_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (exc_valid) begin
            cause_q   <= exc_cause;
            pc_q      <= exc_pc;
            is_irq_q  <= 1'b0;
            is_mret_q <= 1'b0;
            ext_q     <= 1'b0;
            tmr_q     <= 1'b0;
          end else if (mret) begin
            is_irq_q  <= 1'b0;
            is_mret_q <= 1'b1;
          end else if (irq_ext || irq_timer) begin
            pc_q      <= irq_pc;
            is_irq_q  <= 1'b1;
            is_mret_q <= 1'b0;
            ext_q     <= irq_ext;
            tmr_q     <= irq_timer;
          end
        end
        S_RD_MSTATUS: mstatus_q <= csr_rdata;
        S_RD_MIE: begin
          // External wins when both are enabled.
          ext_q <= take_ext;
          tmr_q <= take_tmr & ~take_ext;
        end
        S_RD_MTVEC: target_q <= trap_target;
        S_RD_MEPC:  target_q <= {csr_rdata[XLEN-1:2], 2'b00};
        default: ;
      endcase
    end
  end

endmodule
